// File: rtl/instr_issue.sv
// Instruction fetch-and-issue unit: fetches a word per request/valid handshake,
// issues its opcode downstream, and stalls on branch-class opcodes until resolved.
module instr_issue #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,

  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,

  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [4:0]        opcode,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              illegal,

  input  logic              br_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target
);

  localparam logic [4:0] OP_NOP     = 5'd21;
  localparam logic [4:0] OP_BR_LO   = 5'd16;
  localparam logic [4:0] OP_BR_HI   = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_BRWAIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              ill_q;
  logic [4:0]        op_raw;
  logic [ADDR_W-1:0] pc_inc;

  function automatic logic is_branch(input logic [4:0] op);
    return (op >= OP_BR_LO) && (op <= OP_BR_HI);
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return op > OP_NOP;
  endfunction

  assign op_raw    = imem_rdata[31:27];
  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = pc;

  // NOTE: all state and outputs are registered in one clocked block with
  // non-blocking assignments, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_rd     <= 1'b0;
      issue_valid <= 1'b0;
      opcode      <= OP_NOP;
      instr       <= '0;
      instr_pc    <= '0;
      ill_q       <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          imem_rd <= 1'b1;
          state   <= S_FETCH;
        end
        S_FETCH: begin
          imem_rd <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            ill_q       <= is_illegal(op_raw);
            opcode      <= is_illegal(op_raw) ? OP_NOP : op_raw;
            issue_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            opcode      <= OP_NOP;
            // Illegal words were already mapped to NOP, so they never stall here.
            if (is_branch(opcode)) begin
              state <= S_BRWAIT;
            end else begin
              pc      <= pc_inc;
              imem_rd <= 1'b1;
              illegal <= ill_q;
              state   <= S_FETCH;
            end
          end
        end
        S_BRWAIT: begin
          if (br_done) begin
            pc      <= br_taken ? br_target : pc_inc;
            imem_rd <= 1'b1;
            state   <= S_FETCH;
          end
        end
        default: begin
          imem_rd     <= 1'b0;
          issue_valid <= 1'b0;
          opcode      <= OP_NOP;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: a zero-wait memory model drives fetches,
// expected issues go into a scoreboard that a negedge monitor checks.
module tb_instr_issue;

  localparam int         ADDR_W = 8;
  localparam logic [4:0] NOP    = 5'd21;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic              issue_valid;
  logic              issue_ready;
  logic [4:0]        opcode;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              illegal;
  logic              br_done;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;

  instr_issue #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .illegal     (illegal),
    .br_done     (br_done),
    .br_taken    (br_taken),
    .br_target   (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        op;
    logic [31:0]       word;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  exp_t              sb[$];
  int                hs_cyc[$];
  int                vectors    = 0;
  int                miscompares = 0;
  int                hs_count   = 0;
  int                cyc        = 0;
  logic [31:0]       mem [256];
  logic              mem_en     = 1'b1;
  logic              pend       = 1'b0;
  logic [ADDR_W-1:0] pend_addr  = '0;
  exp_t              mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] word, input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.op = op; e.word = word; e.pc = pc;
    sb.push_back(e);
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge. The memory
  // answers in the cycle following a request (zero wait states).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    imem_valid = pend;
    imem_rdata = pend ? mem[pend_addr] : 32'h0;
    pend       = imem_rd && mem_en;
    pend_addr  = imem_addr;
  endtask

  task automatic wait_issue();
    int k = 0;
    while (!issue_valid && k < 40) begin
      tick();
      k++;
    end
    check("issue_timeout", {31'd0, issue_valid}, 32'd1);
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_count < n && k < 60) begin
      tick();
      k++;
    end
    check("handshake_timeout", {31'd0, hs_count >= n}, 32'd1);
  endtask

  // Entered on the first BRWAIT cycle; br_done goes high after 'dly' cycles.
  task automatic do_branch(input int dly, input logic taken, input logic [ADDR_W-1:0] tgt,
                           input logic [ADDR_W-1:0] next_addr);
    for (int i = 0; i < dly; i++) begin
      check("brwait_valid", {31'd0, issue_valid}, 32'd0);
      check("brwait_opcode", {27'd0, opcode}, {27'd0, NOP});
      tick();
    end
    check("brwait_rd", {31'd0, imem_rd}, 32'd0);
    br_done   = 1'b1;
    br_taken  = taken;
    br_target = tgt;
    tick();
    br_done = 1'b0;
    check("br_fetch_rd", {31'd0, imem_rd}, 32'd1);
    check("br_fetch_addr", {24'd0, imem_addr}, {24'd0, next_addr});
  endtask

  // Monitor: pops the scoreboard on every accepted issue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && issue_valid && issue_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", {24'd0, instr_pc}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          check("issue_opcode", {27'd0, opcode}, {27'd0, mon_e.op});
          check("issue_instr", instr, mon_e.word);
          check("issue_pc", {24'd0, instr_pc}, {24'd0, mon_e.pc});
        end
        hs_count++;
        hs_cyc.push_back(cyc);
      end else if (!issue_valid) begin
        check("idle_opcode_nop", {27'd0, opcode}, {27'd0, NOP});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA800_0000;
    mem[8'h00] = 32'h3000_0000;  // ADD
    mem[8'h01] = 32'h3800_0000;  // SUB
    mem[8'h02] = 32'h4000_0000;  // MUL
    mem[8'h03] = 32'h3000_0000;  // ADD (backpressure)
    mem[8'h04] = 32'h8800_0000;  // JPC
    mem[8'h05] = 32'hA000_0000;  // RET
    mem[8'h20] = 32'h8000_0000;  // JR
    mem[8'hFF] = 32'hC000_1234;  // opcode 24: illegal

    rst_n = 1'b1; issue_ready = 1'b1;
    br_done = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    #1 rst_n = 1'b0;

    // Reset values held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd", {31'd0, imem_rd}, 32'd0);
      check("rst_addr", {24'd0, imem_addr}, 32'd0);
      check("rst_valid", {31'd0, issue_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
    end

    // Sequential stream: ADD, SUB, MUL three cycles apart
    push(5'd6, 32'h3000_0000, 8'h00);
    push(5'd7, 32'h3800_0000, 8'h01);
    push(5'd8, 32'h4000_0000, 8'h02);
    rst_n = 1'b1;
    check("idle_rd", {31'd0, imem_rd}, 32'd0);
    tick();
    check("first_fetch_rd", {31'd0, imem_rd}, 32'd1);
    check("first_fetch_addr", {24'd0, imem_addr}, 32'd0);
    wait_hs(3);
    if (hs_cyc.size() >= 3) begin
      check("stream_gap_1", hs_cyc[1] - hs_cyc[0], 32'd3);
      check("stream_gap_2", hs_cyc[2] - hs_cyc[1], 32'd3);
    end

    // Backpressure on ADD at PC 3
    issue_ready = 1'b0;
    push(5'd6, 32'h3000_0000, 8'h03);
    wait_issue();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, issue_valid}, 32'd1);
      check("bp_opcode", {27'd0, opcode}, 32'd6);
      check("bp_pc", {24'd0, instr_pc}, 32'd3);
      check("bp_no_fetch", {31'd0, imem_rd}, 32'd0);
      tick();
    end
    issue_ready = 1'b1;
    check("bp_no_fetch_ready", {31'd0, imem_rd}, 32'd0);
    tick();
    check("bp_fetch_rd", {31'd0, imem_rd}, 32'd1);
    check("bp_fetch_addr", {24'd0, imem_addr}, 32'd4);
    check("legal_no_pulse", {31'd0, illegal}, 32'd0);

    // Branches: JPC@4 taken to 0x20, JR@0x20 back to 4 (min latency),
    // JPC@4 not taken to 5, RET@5 taken to 0xFF
    push(5'd17, 32'h8800_0000, 8'h04);
    wait_issue(); tick();
    do_branch(2, 1'b1, 8'h20, 8'h20);
    push(5'd16, 32'h8000_0000, 8'h20);
    wait_issue(); tick();
    do_branch(0, 1'b1, 8'h04, 8'h04);
    push(5'd17, 32'h8800_0000, 8'h04);
    wait_issue(); tick();
    do_branch(1, 1'b0, 8'h77, 8'h05);
    push(5'd20, 32'hA000_0000, 8'h05);
    wait_issue(); tick();
    do_branch(0, 1'b1, 8'hFF, 8'hFF);

    // Illegal opcode at 0xFF issues as NOP, pulses illegal, PC wraps to 0
    push(NOP, 32'hC000_1234, 8'hFF);
    wait_issue();
    check("ill_before", {31'd0, illegal}, 32'd0);
    tick();
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    check("wrap_addr", {24'd0, imem_addr}, 32'd0);
    check("wrap_rd", {31'd0, imem_rd}, 32'd1);
    push(5'd6, 32'h3000_0000, 8'h00);
    tick();
    check("ill_one_cycle", {31'd0, illegal}, 32'd0);

    // Reset while waiting on the fetch of PC 1
    wait_issue();
    mem_en = 1'b0;
    tick();
    check("pre_rst_addr", {24'd0, imem_addr}, 32'd1);
    tick(); tick();
    check("stuck_in_wait", {31'd0, issue_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", {31'd0, imem_rd}, 32'd0);
    check("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
    check("mid_rst_opcode", {27'd0, opcode}, {27'd0, NOP});
    check("mid_rst_instr", instr, 32'd0);
    mem_en = 1'b1;
    tick(); tick();
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h4000_0000;
    push(5'd6, 32'h3000_0000, 8'h00);
    tick();
    check("restart_rd", {31'd0, imem_rd}, 32'd1);
    check("restart_addr", {24'd0, imem_addr}, 32'd0);
    check("restart_no_issue", {31'd0, issue_valid}, 32'd0);
    wait_hs(11);
    tick();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
